// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the unified-memory arbiter.
package mem_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;

  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);
endpackage

// File: rtl/arb_select.sv
// Picks the winner between fetch and data requesters.
// MEM_ARB_RR_EN: ties alternate (least recently granted wins); otherwise data wins ties.
module arb_select
  import mem_arb_pkg::*;
(
  input  logic   if_req_i,
  input  logic   d_req_i,
  input  owner_e last_winner_i,
  output owner_e winner_o,
  output logic   valid_o
);

  always_comb begin
    valid_o  = if_req_i | d_req_i;
    winner_o = OWN_D;
    if (if_req_i && !d_req_i) begin
      winner_o = OWN_IF;
    end else if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
      winner_o = (last_winner_i == OWN_IF) ? OWN_D : OWN_IF;
`else
      winner_o = OWN_D;
`endif
    end
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_winner;
  assign unused_last_winner = last_winner_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port memory with fixed read latency.
// MEM_ARB_RR_EN selects round-robin tie breaking; default is data-priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1   // 1..MEM_LAT_MAX
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  owner_e           last_q;
  owner_e           win;
  logic             win_vld;
  logic             grant;
  logic             done;

  arb_select u_sel (
    .if_req_i      (if_req),
    .d_req_i       (d_req),
    .last_winner_i (last_q),
    .winner_o      (win),
    .valid_o       (win_vld)
  );

  // A new grant may overlap the final cycle of the current access.
  assign done  = (state_q == BUSY) && (cnt_q == '0);
  assign grant = ((state_q == IDLE) || (cnt_q == '0)) && win_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      last_q <= OWN_IF;
    else if (grant) last_q <= win;
  end
`else
  assign last_q = OWN_IF;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (grant) begin
      state_d = BUSY;
      owner_d = win;
      cnt_d   = CNT_W'(MEM_LAT - 1);
    end else if (state_q == BUSY) begin
      if (cnt_q == '0) state_d = IDLE;
      else             cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  // Everything is forced low while reset is high, including the combinational paths.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    busy      = 1'b0;
    if (!reset) begin
      if (grant) begin
        mem_en = 1'b1;
        if (win == OWN_D) begin
          d_gnt     = 1'b1;
          mem_we    = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          mem_be    = d_be;
        end else begin
          if_gnt   = 1'b1;
          mem_addr = if_addr;
          mem_be   = '1;
        end
      end
      if (done) begin
        if_rvalid = (owner_q == OWN_IF);
        d_rvalid  = (owner_q == OWN_D);
      end
      if_rdata = mem_rdata;
      d_rdata  = mem_rdata;
      busy     = (state_q == BUSY);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        a_if_req = 0, a_d_req = 0, a_d_we = 0;
  logic [31:0] a_if_addr = 0, a_d_addr = 0, a_d_wdata = 0;
  logic [3:0]  a_d_be = 0;
  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic [31:0] a_mem_rdata = 32'h1111_2222;

  logic        b_if_req = 0, b_d_req = 0, b_d_we = 0;
  logic [31:0] b_if_addr = 0, b_d_addr = 0, b_d_wdata = 0;
  logic [3:0]  b_d_be = 0;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;
  logic [31:0] b_mem_rdata = 32'h3333_4444;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_a (
    .clk(clk), .reset(reset),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata), .d_be(a_d_be),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_be(a_mem_be), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_b (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_be(b_d_be),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_be(b_mem_be), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory models: a read returns its address XOR A5A5_0000, held until the next read.
  always @(posedge clk) if (a_mem_en && !a_mem_we) a_mem_rdata <= a_mem_addr ^ 32'hA5A5_0000;
  always @(posedge clk) if (b_mem_en && !b_mem_we) b_mem_rdata <= b_mem_addr ^ 32'hA5A5_0000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    a_if_req = 1; a_d_req = 1; b_d_req = 1; b_d_we = 1;
    tick; tick;
    n_tests++;
    if ({a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_busy, a_if_rvalid, a_d_rvalid} !== 7'b0) begin
      n_fail++; $display("FAIL reset_a_ctrl: got %b want 0000000", {a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_busy, a_if_rvalid, a_d_rvalid});
    end
    n_tests++;
    if ({b_d_gnt, b_mem_en, b_mem_we, b_busy, b_mem_addr, b_mem_be} !== 40'b0) begin
      n_fail++; $display("FAIL reset_b_ctrl: got %h want 0", {b_d_gnt, b_mem_en, b_mem_we, b_busy, b_mem_addr, b_mem_be});
    end
    n_tests++;
    if ({a_if_rdata, a_d_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", {a_if_rdata, a_d_rdata});
    end
    a_if_req = 0; a_d_req = 0; b_d_req = 0; b_d_we = 0;
    tick;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({a_busy, b_busy, a_mem_en, b_mem_en} !== 4'b0) begin
      n_fail++; $display("FAIL reset_release_idle: got %b want 0000", {a_busy, b_busy, a_mem_en, b_mem_en});
    end
    tick;
  endtask

  task automatic test_fetch_lat1;
    a_if_req = 1; a_if_addr = 32'h10; #1;
    n_tests++;
    if ({a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_busy} !== 5'b10100) begin
      n_fail++; $display("FAIL fetch_grant: got %b want 10100", {a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_busy});
    end
    n_tests++;
    if (a_mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL fetch_addr: got %h want 00000010", a_mem_addr);
    end
    tick; a_if_req = 0; a_if_addr = 0; #1;
    n_tests++;
    if ({a_if_rvalid, a_d_rvalid, a_busy, a_mem_en} !== 4'b1010) begin
      n_fail++; $display("FAIL fetch_rvalid: got %b want 1010", {a_if_rvalid, a_d_rvalid, a_busy, a_mem_en});
    end
    n_tests++;
    if (a_if_rdata !== 32'hA5A5_0010) begin
      n_fail++; $display("FAIL fetch_rdata: got %h want a5a50010", a_if_rdata);
    end
    tick;
    n_tests++;
    if ({a_if_rvalid, a_busy} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_idle: got %b want 00", {a_if_rvalid, a_busy});
    end
  endtask

  task automatic test_write_lat3;
    b_d_req = 1; b_d_we = 1; b_d_addr = 32'h100; b_d_wdata = 32'hDEAD_BEEF; b_d_be = 4'hF; #1;
    n_tests++;
    if ({b_d_gnt, b_if_gnt, b_mem_en, b_mem_we, b_busy} !== 5'b10110) begin
      n_fail++; $display("FAIL wr_grant: got %b want 10110", {b_d_gnt, b_if_gnt, b_mem_en, b_mem_we, b_busy});
    end
    n_tests++;
    if ({b_mem_addr, b_mem_wdata, b_mem_be} !== {32'h100, 32'hDEAD_BEEF, 4'hF}) begin
      n_fail++; $display("FAIL wr_fields: got %h want 00000100deadbeeff", {b_mem_addr, b_mem_wdata, b_mem_be});
    end
    tick; b_d_req = 0; b_d_we = 0; b_if_req = 1; b_if_addr = 32'h200; #1;
    for (int k = 1; k <= 2; k++) begin
      n_tests++;
      if ({b_if_gnt, b_d_gnt, b_mem_en, b_d_rvalid, b_busy} !== 5'b00001) begin
        n_fail++; $display("FAIL wr_wait%0d: got %b want 00001", k, {b_if_gnt, b_d_gnt, b_mem_en, b_d_rvalid, b_busy});
      end
      tick;
    end
    n_tests++;
    if ({b_d_rvalid, b_if_rvalid, b_if_gnt, b_mem_en, b_mem_we, b_busy} !== 6'b101101) begin
      n_fail++; $display("FAIL wr_done_b2b: got %b want 101101", {b_d_rvalid, b_if_rvalid, b_if_gnt, b_mem_en, b_mem_we, b_busy});
    end
    tick; b_if_req = 0; b_if_addr = 0; #1;
    for (int k = 4; k <= 5; k++) begin
      n_tests++;
      if ({b_if_rvalid, b_mem_en, b_busy} !== 3'b001) begin
        n_fail++; $display("FAIL fetch3_wait%0d: got %b want 001", k, {b_if_rvalid, b_mem_en, b_busy});
      end
      tick;
    end
    n_tests++;
    if ({b_if_rvalid, b_d_rvalid, b_if_rdata} !== {2'b10, 32'hA5A5_0200}) begin
      n_fail++; $display("FAIL fetch3_rvalid: got %h want 2a5a50200", {b_if_rvalid, b_d_rvalid, b_if_rdata});
    end
    tick;
    n_tests++;
    if (b_busy !== 1'b0) begin
      n_fail++; $display("FAIL fetch3_idle: got %b want 0", b_busy);
    end
  endtask

  task automatic test_tie;
    logic [3:0] exp_d;
`ifdef MEM_ARB_RR_EN
    exp_d = 4'b0101;
`else
    exp_d = 4'b1111;
`endif
    a_if_req = 1; a_if_addr = 32'h40; a_d_req = 1; a_d_we = 0; a_d_addr = 32'h80; #1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({a_d_gnt, a_if_gnt, a_mem_en} !== {exp_d[k], ~exp_d[k], 1'b1}) begin
        n_fail++; $display("FAIL tie_grant%0d: got %b want %b", k, {a_d_gnt, a_if_gnt, a_mem_en}, {exp_d[k], ~exp_d[k], 1'b1});
      end
      if (k > 0) begin
        n_tests++;
        if ({a_d_rvalid, a_if_rvalid, a_d_rdata} !== {exp_d[k-1], ~exp_d[k-1], exp_d[k-1] ? 32'hA5A5_0080 : 32'hA5A5_0040}) begin
          n_fail++; $display("FAIL tie_resp%0d: got %b %b %h want d=%b", k, a_d_rvalid, a_if_rvalid, a_d_rdata, exp_d[k-1]);
        end
      end
      tick;
    end
    a_if_req = 0; a_d_req = 0; #1;
    n_tests++;
    if ({a_d_rvalid, a_if_rvalid, a_mem_en} !== {exp_d[3], ~exp_d[3], 1'b0}) begin
      n_fail++; $display("FAIL tie_last: got %b want %b", {a_d_rvalid, a_if_rvalid, a_mem_en}, {exp_d[3], ~exp_d[3], 1'b0});
    end
    tick;
  endtask

  task automatic test_back_to_back;
    a_if_req = 1; a_if_addr = 32'h20; #1;
    n_tests++;
    if ({a_if_gnt, a_d_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_fetch_gnt: got %b want 10", {a_if_gnt, a_d_gnt});
    end
    tick; a_if_req = 0; a_d_req = 1; a_d_we = 0; a_d_addr = 32'h30; #1;
    n_tests++;
    if ({a_if_rvalid, a_d_gnt, a_mem_en, a_busy, a_if_rdata} !== {4'b1111, 32'hA5A5_0020}) begin
      n_fail++; $display("FAIL b2b_overlap: got %b %h want 1111 a5a50020", {a_if_rvalid, a_d_gnt, a_mem_en, a_busy}, a_if_rdata);
    end
    tick; a_d_req = 0; #1;
    n_tests++;
    if ({a_d_rvalid, a_if_rvalid, a_mem_en, a_d_rdata} !== {3'b100, 32'hA5A5_0030}) begin
      n_fail++; $display("FAIL b2b_data_resp: got %b %h want 100 a5a50030", {a_d_rvalid, a_if_rvalid, a_mem_en}, a_d_rdata);
    end
    tick;
  endtask

  task automatic test_reset_inflight;
    b_d_req = 1; b_d_we = 1; b_d_addr = 32'h180; b_d_wdata = 32'h1234_5678; b_d_be = 4'h3; #1;
    n_tests++;
    if (b_d_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rst_fl_gnt: got %b want 1", b_d_gnt);
    end
    tick; b_d_req = 0; b_d_we = 0; #1;
    n_tests++;
    if (b_busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_fl_busy: got %b want 1", b_busy);
    end
    reset = 1; #1;
    n_tests++;
    if ({b_busy, b_mem_en, b_d_rvalid, b_d_gnt, b_if_gnt, b_mem_we, b_d_rdata} !== 38'b0) begin
      n_fail++; $display("FAIL rst_fl_outs: got %h want 0", {b_busy, b_mem_en, b_d_rvalid, b_d_gnt, b_if_gnt, b_mem_we, b_d_rdata});
    end
    for (int k = 0; k < 2; k++) begin
      tick;
      n_tests++;
      if ({b_d_rvalid, b_busy} !== 2'b00) begin
        n_fail++; $display("FAIL rst_fl_hold%0d: got %b want 00", k, {b_d_rvalid, b_busy});
      end
    end
    reset = 0; b_d_req = 1; b_d_we = 0; b_d_addr = 32'h300; #1;
    n_tests++;
    if ({b_d_gnt, b_mem_en, b_busy, b_d_rvalid} !== 4'b1100) begin
      n_fail++; $display("FAIL rst_new_gnt: got %b want 1100", {b_d_gnt, b_mem_en, b_busy, b_d_rvalid});
    end
    tick; b_d_req = 0; #1;
    for (int k = 1; k <= 2; k++) begin
      n_tests++;
      if ({b_d_rvalid, b_busy} !== 2'b01) begin
        n_fail++; $display("FAIL rst_new_wait%0d: got %b want 01", k, {b_d_rvalid, b_busy});
      end
      tick;
    end
    n_tests++;
    if ({b_d_rvalid, b_d_rdata} !== {1'b1, 32'hA5A5_0300}) begin
      n_fail++; $display("FAIL rst_new_resp: got %b %h want 1 a5a50300", b_d_rvalid, b_d_rdata);
    end
    tick;
    n_tests++;
    if ({b_d_rvalid, b_busy} !== 2'b00) begin
      n_fail++; $display("FAIL rst_new_idle: got %b want 00", {b_d_rvalid, b_busy});
    end
  endtask

  initial begin
    test_reset;
    test_fetch_lat1;
    test_write_lat3;
    test_tie;
    test_back_to_back;
    test_reset_inflight;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
